// File: rtl/bt_uart_pkg.sv
// Shared definitions for the Bluetooth UART link: clock/baud defaults,
// transmitter FSM encoding, FIFO word layout and protocol ASCII constants.
package bt_uart_pkg;

   localparam int DEFAULT_CLK_HZ   = 50_000_000;
   localparam int DEFAULT_BIT_RATE = 115_200;

   localparam logic [7:0] CH_A    = 8'h41;
   localparam logic [7:0] CH_C    = 8'h43;
   localparam logic [7:0] CH_D    = 8'h44;
   localparam logic [7:0] CH_HASH = 8'h23;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_e;

   typedef struct packed {
      logic       last;
      logic [7:0] data;
   } tx_word_t;

   function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
      return clk_hz / bit_rate;
   endfunction

endpackage

// File: rtl/bluetooth_transmitter_if.sv
// Host-side byte write port of the Bluetooth transmitter.
interface bluetooth_transmitter_if #(
   parameter int FIFO_DEPTH = 16
) ();

   logic                        wr_en;
   logic [7:0]                  wr_data;
   logic                        wr_last;
   logic                        wr_ready;
   logic                        overflow;
   logic [$clog2(FIFO_DEPTH):0] fifo_level;

   modport master (
      output wr_en, wr_data, wr_last,
      input  wr_ready, overflow, fifo_level
   );

   modport slave (
      input  wr_en, wr_data, wr_last,
      output wr_ready, overflow, fifo_level
   );

endinterface

// File: rtl/bt_tx_fifo.sv
// Synchronous FIFO with wrapping pointers, registered full flag, level count
// and a one-cycle overflow pulse on a write attempted while full.
module bt_tx_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   output logic                     wr_ready,
   output logic                     overflow,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             full_q, full_d, ovf_q, ovf_d;
   logic             push, pop;

   // NOTE: every always_comb output gets a value up front so no path can infer a latch.
   always_comb begin
      push     = wr_en & ~full_q;
      pop      = rd_en & (level_q != '0);
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      level_d  = level_q + LW'(push) - LW'(pop);
      full_d   = (level_d == LW'(DEPTH));
      ovf_d    = wr_en & full_q;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         full_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         full_q   <= full_d;
         ovf_q    <= ovf_d;
      end
   end

   // NOTE: storage is not reset; the pointers and level alone define what is valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_data;
   end

   assign rd_data  = mem_q[rd_ptr_q];
   assign empty    = (level_q == '0);
   assign level    = level_q;
   assign wr_ready = ~full_q;
   assign overflow = ovf_q;

endmodule

// File: rtl/bluetooth_transmitter.sv
// Buffered 8N1 UART transmitter, LSB first, frames sent back to back.
// Define BT_TX_TERM_EN to append a TERM_CHAR frame after each byte written with wr_last.
module bluetooth_transmitter
   import bt_uart_pkg::*;
#(
   parameter int         CLK_HZ       = DEFAULT_CLK_HZ,
   parameter int         BIT_RATE     = DEFAULT_BIT_RATE,
   parameter int         PAYLOAD_BITS = 8,
   parameter int         FIFO_DEPTH   = 16,
   parameter logic [7:0] TERM_CHAR    = CH_HASH
) (
   input  logic                    clk,
   input  logic                    resetn,
   bluetooth_transmitter_if.slave  wr_if,
   output logic                    tx_busy,
   output logic                    uart_txd
);

   localparam int CPB   = cycles_per_bit(CLK_HZ, BIT_RATE);
   localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
   localparam int BIT_W = $clog2(PAYLOAD_BITS);
   localparam logic [CNT_W-1:0] CPB_M1   = CNT_W'(CPB - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAYLOAD_BITS - 1);

   tx_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [BIT_W-1:0] bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             txd_q, txd_d;
   logic             bit_end, take, fifo_pop, fifo_empty;
   tx_word_t         rd_word;

   bt_tx_fifo #(
      .WIDTH ($bits(tx_word_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .resetn   (resetn),
      .wr_en    (wr_if.wr_en),
      .wr_data  ({wr_if.wr_last, wr_if.wr_data}),
      .wr_ready (wr_if.wr_ready),
      .overflow (wr_if.overflow),
      .rd_en    (fifo_pop),
      .rd_data  (rd_word),
      .empty    (fifo_empty),
      .level    (wr_if.fifo_level)
   );

`ifdef BT_TX_TERM_EN
   logic last_q, last_d;
`else
   logic [8:0] unused_cfg;
   assign unused_cfg = {rd_word.last, TERM_CHAR};
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + 1'b1;
      bit_d    = bit_q;
      shift_d  = shift_q;
      txd_d    = txd_q;
      fifo_pop = 1'b0;
      take     = 1'b0;
`ifdef BT_TX_TERM_EN
      last_d   = last_q;
`endif
      bit_end  = (cnt_q == CPB_M1);

      unique case (state_q)
         TX_IDLE: begin
            cnt_d = '0;
            take  = ~fifo_empty;
         end
         TX_START: begin
            if (bit_end) begin
               state_d = TX_DATA;
               txd_d   = shift_q[0];
            end
         end
         TX_DATA: begin
            if (bit_end) begin
               if (bit_q == BIT_LAST) begin
                  state_d = TX_STOP;
                  txd_d   = 1'b1;
                  bit_d   = '0;
               end else begin
                  bit_d   = bit_q + 1'b1;
                  shift_d = shift_q >> 1;
                  txd_d   = shift_q[1];
               end
            end
         end
         TX_STOP: begin
            if (bit_end) begin
`ifdef BT_TX_TERM_EN
               if (last_q) begin
                  shift_d = TERM_CHAR;
                  last_d  = 1'b0;
                  state_d = TX_START;
                  txd_d   = 1'b0;
               end else
`endif
               if (!fifo_empty) begin
                  take = 1'b1;
               end else begin
                  state_d = TX_IDLE;
                  txd_d   = 1'b1;
               end
            end
         end
         default: state_d = TX_IDLE;
      endcase

      if (bit_end) cnt_d = '0;

      // Popping a byte always begins a start bit on the following edge.
      if (take) begin
         fifo_pop = 1'b1;
         shift_d  = rd_word.data;
         state_d  = TX_START;
         txd_d    = 1'b0;
         cnt_d    = '0;
`ifdef BT_TX_TERM_EN
         last_d   = rd_word.last;
`endif
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= TX_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         txd_q   <= 1'b1;
`ifdef BT_TX_TERM_EN
         last_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         txd_q   <= txd_d;
`ifdef BT_TX_TERM_EN
         last_q  <= last_d;
`endif
      end
   end

   assign uart_txd = txd_q;
   assign tx_busy  = (state_q != TX_IDLE) | ~fifo_empty;

endmodule
